t02_wb_master: RTL and testbench

//  Memory-side bridge directly downstream of the CPU request unit. Converts the CPU's

---
 rtl/t02_wb_pkg.sv | 14 +
 rtl/t02_wb_timeout.sv | 30 +++
 rtl/t02_wb_master.sv | 111 +++++++++++
 tb/tb_t02_wb_master.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/t02_wb_pkg.sv
// Shared types and constants for the t02 Wishbone-classic master bridge.
// The T02_WB_TIMEOUT_EN build option is consumed by t02_wb_master.sv.
package t02_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } t02_wb_state_t;

  localparam logic [3:0]  WB_SEL_WORD     = 4'hF;
  localparam logic [31:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/t02_wb_timeout.sv
// Bus-cycle watchdog for the t02 Wishbone master; expired is high during the
// TIMEOUT_CYCLES-th consecutive enabled cycle after a clear.
module t02_wb_timeout
  import t02_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Counter parks at the terminal value so expired stays asserted until cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/t02_wb_master.sv
// CPU request to Wishbone-classic single-transfer bridge.
// Optional bus watchdog enabled by defining T02_WB_TIMEOUT_EN.
module t02_wb_master
  import t02_wb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Ren,
  input  logic                Wen,
  input  logic [ADDR_W-1:0]   ramaddr,
  input  logic [DATA_W-1:0]   ramstore,
  output logic [DATA_W-1:0]   ramload,
  output logic                busy_o,
  output logic                err_o,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [DATA_W-1:0]   dat_o,
  output logic [DATA_W/8-1:0] sel_o,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic                ack_i
);

  t02_wb_state_t state, state_nxt;

  logic req;
  logic take;
  logic done_ack;
  logic abort;

  assign req      = Ren | Wen;
  assign take     = (state == IDLE) && req;
  assign done_ack = (state == BUS) && ack_i;

`ifdef T02_WB_TIMEOUT_EN
  logic expired;

  t02_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (take),
    .enable (state == BUS),
    .expired(expired)
  );

  // A real ack in the expiring cycle still wins over the abort.
  assign abort = (state == BUS) && !ack_i && expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else begin
      err_o <= abort;
    end
  end
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  assign busy_o = (state == BUS) || take;
  assign sel_o  = {(DATA_W/8){1'b1}};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = BUS;
      BUS:     if (ack_i || abort) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Wishbone outputs are registered; request fields are frozen at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      we_o    <= 1'b0;
      adr_o   <= '0;
      dat_o   <= '0;
      ramload <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= Wen;
        adr_o <= ramaddr;
        dat_o <= ramstore;
      end else if (done_ack || abort) begin
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
      end
      if (done_ack && !we_o) begin
        ramload <= dat_i;
      end else if (abort && !we_o) begin
        ramload <= DATA_W'(WB_TIMEOUT_DATA);
      end
    end
  end

endmodule

// File: tb/tb_t02_wb_master.sv
// Directed self-checking bench for t02_wb_master; honours T02_WB_TIMEOUT_EN
// (instantiated with TIMEOUT_CYCLES=8).
module tb_t02_wb_master;

  logic        clk;
  logic        rst;
  logic        Ren, Wen;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        busy_o, err_o, cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  t02_wb_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .busy_o(busy_o), .err_o(err_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs for the new cycle are set after this.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; Ren = 0; Wen = 0; ack_i = 0; ramaddr = 0; ramstore = 0; dat_i = 0;
    tick(); tick();
    #1;
    n_checks++;
    if ({cyc_o, stb_o, we_o, err_o, busy_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got cyc/stb/we/err/busy=%b expected 00000",
                         {cyc_o, stb_o, we_o, err_o, busy_o});
    end
    n_checks++;
    if ({adr_o, dat_o, ramload} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: got adr=%h dat=%h ramload=%h expected all 0",
                         adr_o, dat_o, ramload);
    end
    n_checks++;
    if (sel_o !== 4'hF) begin
      n_fail++; $display("FAIL reset_sel: got %h expected f", sel_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_zero_wait();
    Ren = 1; ramaddr = 32'h100; #1;
    n_checks++;
    if ({busy_o, cyc_o} !== 2'b10) begin
      n_fail++; $display("FAIL rd_c0: got busy,cyc=%b expected 10", {busy_o, cyc_o});
    end
    tick();
    ack_i = 1; dat_i = 32'h1234_5678; #1;
    n_checks++;
    if ({cyc_o, stb_o, busy_o, we_o} !== 4'b1110 || adr_o !== 32'h100) begin
      n_fail++; $display("FAIL rd_c1: got cyc,stb,busy,we=%b adr=%h expected 1110 adr=100",
                         {cyc_o, stb_o, busy_o, we_o}, adr_o);
    end
    tick();
    Ren = 0; ack_i = 0; dat_i = 32'h0; #1;
    n_checks++;
    if ({cyc_o, stb_o, busy_o} !== 3'b000 || ramload !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rd_c2: got cyc,stb,busy=%b ramload=%h expected 000 12345678",
                         {cyc_o, stb_o, busy_o}, ramload);
    end
    tick();
  endtask

  task automatic test_write_wait_states();
    Wen = 1; ramaddr = 32'h200; ramstore = 32'hCAFE_F00D; #1;
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL wr_c0_busy: got %b expected 1", busy_o);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 2) begin ramaddr = 32'h777; ramstore = 32'h1111_2222; end
      ack_i = (c == 4); #1;
      n_checks++;
      if ({cyc_o, stb_o, we_o, busy_o} !== 4'b1111 || adr_o !== 32'h200 ||
          dat_o !== 32'hCAFE_F00D || sel_o !== 4'hF) begin
        n_fail++; $display("FAIL wr_bus_c%0d: got ctl=%b adr=%h dat=%h sel=%h expected 1111 200 cafef00d f",
                           c, {cyc_o, stb_o, we_o, busy_o}, adr_o, dat_o, sel_o);
      end
    end
    tick();
    Wen = 0; ack_i = 0; #1;
    n_checks++;
    if ({cyc_o, busy_o} !== 2'b00 || ramload !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wr_c5: got cyc,busy=%b ramload=%h expected 00 12345678",
                         {cyc_o, busy_o}, ramload);
    end
    tick();
  endtask

  task automatic test_both_and_addr_hold();
    Ren = 1; Wen = 1; ramaddr = 32'h300; ramstore = 32'h55AA_55AA;
    tick();
    ramaddr = 32'h999; dat_i = 32'hFFFF_FFFF; #1;
    n_checks++;
    if (we_o !== 1'b1 || dat_o !== 32'h55AA_55AA) begin
      n_fail++; $display("FAIL both_we: got we=%b dat=%h expected 1 55aa55aa", we_o, dat_o);
    end
    tick();
    ack_i = 1; #1;
    n_checks++;
    if (adr_o !== 32'h300 || cyc_o !== 1'b1) begin
      n_fail++; $display("FAIL addr_hold: got adr=%h cyc=%b expected 300 1", adr_o, cyc_o);
    end
    tick();
    Ren = 0; Wen = 0; ack_i = 0; #1;
    n_checks++;
    if (busy_o !== 1'b0 || ramload !== 32'h1234_5678) begin
      n_fail++; $display("FAIL both_done: got busy=%b ramload=%h expected 0 12345678", busy_o, ramload);
    end
    tick();
  endtask

  task automatic test_reset_mid_bus();
    Ren = 1; ramaddr = 32'h400;
    tick();
    tick();
    rst = 1; Ren = 0;
    tick();
    rst = 0; ack_i = 1; dat_i = 32'hFFFF_0000; #1;
    n_checks++;
    if ({cyc_o, stb_o, busy_o} !== 3'b000 || ramload !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid: got cyc,stb,busy=%b ramload=%h expected 000 0",
                         {cyc_o, stb_o, busy_o}, ramload);
    end
    tick();
    ack_i = 0; #1;
    n_checks++;
    if ({cyc_o, busy_o, err_o} !== 3'b000 || ramload !== 32'h0) begin
      n_fail++; $display("FAIL late_ack: got cyc,busy,err=%b ramload=%h expected 000 0",
                         {cyc_o, busy_o, err_o}, ramload);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    Ren = 1; ramaddr = 32'h500;
    tick();
    ack_i = 1; dat_i = 32'hA5A5_A5A5;
    tick();
    ack_i = 0; #1;
    n_checks++;
    if ({busy_o, cyc_o} !== 2'b00 || ramload !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL b2b_done1: got busy,cyc=%b ramload=%h expected 00 a5a5a5a5",
                         {busy_o, cyc_o}, ramload);
    end
    tick();
    ramaddr = 32'h504; #1;
    n_checks++;
    if ({busy_o, cyc_o} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_req2: got busy,cyc=%b expected 10", {busy_o, cyc_o});
    end
    tick();
    ack_i = 1; dat_i = 32'h0BAD_F00D; #1;
    n_checks++;
    if (cyc_o !== 1'b1 || adr_o !== 32'h504) begin
      n_fail++; $display("FAIL b2b_bus2: got cyc=%b adr=%h expected 1 504", cyc_o, adr_o);
    end
    tick();
    Ren = 0; ack_i = 0; #1;
    n_checks++;
    if (busy_o !== 1'b0 || ramload !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL b2b_done2: got busy=%b ramload=%h expected 0 0badf00d", busy_o, ramload);
    end
    tick();
  endtask

  task automatic test_timeout();
    Ren = 1; ramaddr = 32'h600;
`ifdef T02_WB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      tick(); #1;
      n_checks++;
      if ({cyc_o, busy_o, err_o} !== 3'b110) begin
        n_fail++; $display("FAIL to_bus_c%0d: got cyc,busy,err=%b expected 110", c, {cyc_o, busy_o, err_o});
      end
    end
    tick();
    Ren = 0; #1;
    n_checks++;
    if ({cyc_o, busy_o, err_o} !== 3'b001 || ramload !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL to_done: got cyc,busy,err=%b ramload=%h expected 001 deadbeef",
                         {cyc_o, busy_o, err_o}, ramload);
    end
    tick(); #1;
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL to_err_pulse: got %b expected 0", err_o);
    end
`else
    for (int c = 1; c <= 20; c++) begin
      tick(); #1;
      n_checks++;
      if ({cyc_o, busy_o, err_o} !== 3'b110) begin
        n_fail++; $display("FAIL noto_bus_c%0d: got cyc,busy,err=%b expected 110", c, {cyc_o, busy_o, err_o});
      end
    end
    ack_i = 1; dat_i = 32'h600D_600D;
    tick();
    Ren = 0; ack_i = 0; #1;
    n_checks++;
    if (busy_o !== 1'b0 || ramload !== 32'h600D_600D) begin
      n_fail++; $display("FAIL noto_done: got busy=%b ramload=%h expected 0 600d600d", busy_o, ramload);
    end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait_states();
    test_both_and_addr_hold();
    test_reset_mid_bus();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
